// File: rtl/pc_fetch_if.sv
//------------------------------------------------------------------------------
// Module  : pc_fetch_if
// Brief   : Fetch-side bus between the PC sequencer and the decode/control stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  stall;
  logic                  resume;
  logic                  PCsrc;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic [DATA_WIDTH-1:0] A;
  logic                  fetch_valid;
  logic                  halted;
  logic                  trap;
  logic [CNT_WIDTH-1:0]  branch_cnt;

  // Decode/control side: drives control inputs and observes the address.
  modport master (
    output stall, resume, PCsrc, ImmOp,
    input  A, fetch_valid, halted, trap, branch_cnt
  );

  // Sequencer side.
  modport slave (
    input  stall, resume, PCsrc, ImmOp,
    output A, fetch_valid, halted, trap, branch_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
//------------------------------------------------------------------------------
// Module  : pc_fetch
// Brief   : Program counter / fetch sequencer with boot, stall, halt-on-self-branch,
//           misaligned-target trap and saturating taken-branch counter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int                    CNT_WIDTH    = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pc_fetch_if.slave     bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_trap;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_seq;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_self_branch;
  logic                  w_misaligned;

  // Both sums wrap modulo 2^DATA_WIDTH; ImmOp arrives already sign-extended.
  assign w_target      = r_pc + bus.ImmOp;
  assign w_pc_seq      = r_pc + c_PC_STEP;
  assign w_cnt_inc     = (&r_cnt) ? r_cnt : (r_cnt + c_CNT_ONE);
  assign w_self_branch = (bus.ImmOp == '0);
  assign w_misaligned  = (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_trap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (bus.stall) begin
            r_state <= S_RUN;
          end else if (bus.PCsrc && w_self_branch) begin
            r_cnt   <= w_cnt_inc;
            r_state <= S_HALT;
          end else if (bus.PCsrc && w_misaligned) begin
            r_trap  <= 1'b1;
            r_state <= S_HALT;
          end else if (bus.PCsrc) begin
            r_pc  <= w_target;
            r_cnt <= w_cnt_inc;
          end else begin
            r_pc <= w_pc_seq;
          end
        end
        S_HALT: begin
          // Resuming steps past the halting instruction instead of re-executing it.
          if (bus.resume) begin
            r_pc    <= w_pc_seq;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign bus.A           = r_pc;
  assign bus.fetch_valid = (r_state == S_RUN);
  assign bus.halted      = (r_state == S_HALT);
  assign bus.trap        = r_trap;
  assign bus.branch_cnt  = r_cnt;

endmodule

`default_nettype wire
